dense_sequencer: RTL and testbench
==================================

# dense_sequencer

Control FSM that drives one dense layer pass over the MAC engine array. It walks every input activation of every output tile. It issues matched weight and activation memory reads, then delays the MAC enable and accumulate controls to line up with the returned read data. It presents each finished tile to downstream through a valid/ready handshake. The block sits between the layer memories and the dense MAC array, and runs once per `start_i`.

## Interface
- `AddrW`, 16: width of the weight and activation read addresses.
- `LenW`, 12: width of the input-length and tile-count fields.
- `MemLatency`, 2: cycles from `rd_en_o` to read data arriving at the MAC inputs (≥1).
- `MacLatency`, 1: cycles from the last `mac_en_o` until the MAC output is stable (≥1).

- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle start pulse; sampled only in IDLE.
- `in_len_i` in LenW: input activations per tile (K); latched at start.
- `tile_count_i` in LenW: output tiles to compute (T); latched at start.
- `hold_i` in 1: memory busy; suppresses new reads this cycle.
- `wgt_addr_o` out AddrW: weight read address.
- `act_addr_o` out AddrW: activation read address.
- `rd_en_o` out 1: read strobe for both memories.
- `mac_en_o` out 1: MAC engine enable, aligned with data.
- `accumulate_o` out 1: 0 on the first product of a tile, 1 afterwards.
- `result_valid_o` out 1: tile result on the MAC outputs is valid.
- `result_ready_i` in 1: downstream accepts the tile.
- `tile_o` out LenW: index of the current tile.
- `busy_o` out 1: high whenever the FSM is not in IDLE.
- `done_o` out 1: one-cycle pulse when the pass completes.

## Operation
- States: IDLE, ISSUE, DRAIN, OUTPUT.
- IDLE:
  - On `start_i`, latch K and T, and clear k, tile and wgt_base.
  - If K==0 or T==0, pulse `done_o` on the next cycle and stay in IDLE, with no reads issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - Each cycle with `hold_i`=0: `rd_en_o`=1, `act_addr_o`=k, `wgt_addr_o`=wgt_base+k, then k increments.
  - With `hold_i`=1, `rd_en_o`=0 and k holds.
  - After the read with k==K-1 is issued, go to DRAIN.
- Alignment pipeline:
  - A MemLatency-deep shift register carries {valid, first}. It shifts every cycle in every state and is never stalled.
  - first = (k==0) at issue time.
  - At the pipeline output: `mac_en_o`=valid and `accumulate_o`=valid & ~first.
  - `accumulate_o` is 0 whenever `mac_en_o` is 0.
- DRAIN:
  - Wait until the pipeline is empty, then MacLatency further cycles.
  - Then go to OUTPUT.
- OUTPUT:
  - `result_valid_o`=1, holding until `result_ready_i`.
  - On handshake with tile==T-1: pulse `done_o` and go to IDLE.
  - On handshake otherwise: tile+1, wgt_base+=K, k=0, go to ISSUE.
- Arithmetic:
  - Address sums are truncated to AddrW and wrap modulo 2^AddrW; no error is flagged.
  - The tile counter never exceeds T-1.
- Config changes and `start_i` while busy are ignored.
- Reset at any point:
  - Returns immediately to IDLE and clears the pipeline.
  - All outputs are 0: addresses 0, `tile_o` 0, all strobes 0, `busy_o` 0.

## Timing
- Start in cycle 0 with K>0 and T>0: ISSUE in cycle 1, where the first `rd_en_o` (k=0) is asserted.
- `mac_en_o` for a read issued in cycle c is asserted in cycle c+MemLatency.
- With no holds, tile latency from the first read to `result_valid_o` is K+MemLatency+MacLatency cycles.
- `result_valid_o` asserts in the first OUTPUT cycle.
- The handshake cycle is the last OUTPUT cycle, and the next tile's first read follows in the next cycle.
- `done_o` is asserted in the cycle after the final handshake, coincident with IDLE.
- A new `start_i` is accepted in the cycle `done_o` is high.
- `hold_i` adds exactly one cycle per held ISSUE cycle. It does not affect DRAIN or OUTPUT.
- `busy_o` rises the cycle after an accepted start and falls with `done_o`.

## Test plan
- Basic pass, K=4, T=1, no hold, ready tied high (defaults):
  - Reads at k=0..3 in cycles 1–4.
  - `mac_en_o` in cycles 3–6, with `accumulate_o` pattern 0,1,1,1.
  - `result_valid_o` in cycle 8; `done_o` in cycle 9.
- Multi-tile, K=3, T=3:
  - `wgt_addr_o` sequence 0,1,2 | 3,4,5 | 6,7,8; `act_addr_o` repeats 0,1,2 for each tile.
  - `tile_o` steps 0→1→2.
  - Exactly three handshakes, then one `done_o`.
- Hold and backpressure, K=4, T=2:
  - Assert `hold_i` on the 2nd and 3rd ISSUE cycles: reads stretch to 6 cycles with no duplicate addresses, and `mac_en_o` shows the matching gaps.
  - Hold `result_ready_i` low for 5 cycles: `result_valid_o` stays high and `tile_o` stays stable.
- Zero length:
  - K=0, T=5: `done_o` one cycle after start, and `rd_en_o`/`mac_en_o` are never asserted.
  - T=0 gives the same result.
- Start while busy, plus mid-run reset:
  - A second `start_i` with new K is ignored, and the address sequence is unchanged.
  - Dropping `rst_ni` in cycle 3 of ISSUE zeros all outputs asynchronously.
  - A fresh start after reset produces a clean pass from k=0.
- Address wrap, AddrW=4, K=5, T=4:
  - Tile 3 `wgt_addr_o` is 15,0,1,2,3.

Source files
------------

// File: rtl/dense_sequencer.sv
// Dense-layer control FSM: walks K activations per output tile over T tiles, issues
// paired weight/activation reads and aligns MAC enable/accumulate with returning data.
module dense_sequencer #(
    parameter int unsigned AddrW      = 16,
    parameter int unsigned LenW       = 12,
    parameter int unsigned MemLatency = 2,
    parameter int unsigned MacLatency = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LenW-1:0]  in_len_i,
    input  logic [LenW-1:0]  tile_count_i,
    input  logic             hold_i,
    output logic [AddrW-1:0] wgt_addr_o,
    output logic [AddrW-1:0] act_addr_o,
    output logic             rd_en_o,
    output logic             mac_en_o,
    output logic             accumulate_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic [LenW-1:0]  tile_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned DrainW = (MacLatency > 1) ? $clog2(MacLatency) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [LenW-1:0]       r_len;
    logic [LenW-1:0]       r_tiles;
    logic [LenW-1:0]       r_k;
    logic [LenW-1:0]       r_tile;
    logic [AddrW-1:0]      r_wgt_addr;
    logic [MemLatency-1:0] r_pipe_vld;
    logic [MemLatency-1:0] r_pipe_acc;
    logic [DrainW-1:0]     r_drain_cnt;
    logic                  r_busy;
    logic                  r_result_valid;
    logic                  r_done;

    logic                  w_start;
    logic                  w_start_zero;
    logic                  w_issue;
    logic                  w_handshake;
    logic                  w_last_tile;
    logic                  w_pipe_empty;
    logic [MemLatency:0]   w_vld_chain;
    logic [MemLatency:0]   w_acc_chain;

    assign w_pipe_empty = ~|r_pipe_vld;
    assign w_last_tile  = (r_tile == r_tiles - LenW'(1));
    // Pipeline entry carries the issue strobe and whether this read accumulates
    assign w_vld_chain  = {r_pipe_vld, w_issue};
    assign w_acc_chain  = {r_pipe_acc, w_issue & (r_k != '0)};

    // Next-state and per-cycle control decode
    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_start_zero = 1'b0;
        w_issue      = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_start = 1'b1;
                    if (in_len_i == '0 || tile_count_i == '0) begin
                        w_start_zero = 1'b1;
                    end else begin
                        w_state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!hold_i) begin
                    w_issue = 1'b1;
                    if (r_k == r_len - LenW'(1)) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_pipe_empty && r_drain_cnt == DrainW'(MacLatency - 1)) begin
                    w_state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                if (result_ready_i) begin
                    w_handshake = 1'b1;
                    w_state_nxt = w_last_tile ? IDLE : ISSUE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, alignment pipeline and registered status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len          <= '0;
            r_tiles        <= '0;
            r_k            <= '0;
            r_tile         <= '0;
            r_wgt_addr     <= '0;
            r_pipe_vld     <= '0;
            r_pipe_acc     <= '0;
            r_drain_cnt    <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_pipe_vld     <= w_vld_chain[MemLatency-1:0];
            r_pipe_acc     <= w_acc_chain[MemLatency-1:0];
            r_busy         <= (w_state_nxt != IDLE);
            r_result_valid <= (w_state_nxt == OUTPUT);
            r_done         <= w_start_zero | (w_handshake & w_last_tile);

            if (w_start) begin
                r_len      <= in_len_i;
                r_tiles    <= tile_count_i;
                r_k        <= '0;
                r_tile     <= '0;
                r_wgt_addr <= '0;
            end
            // Weight address runs on across tiles, so it lands on base+K for the next tile
            if (w_issue) begin
                r_k        <= r_k + LenW'(1);
                r_wgt_addr <= r_wgt_addr + AddrW'(1);
            end
            if (w_handshake && !w_last_tile) begin
                r_tile <= r_tile + LenW'(1);
                r_k    <= '0;
            end

            if (r_state == DRAIN && w_pipe_empty) begin
                r_drain_cnt <= r_drain_cnt + DrainW'(1);
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    assign wgt_addr_o     = r_wgt_addr;
    assign act_addr_o     = AddrW'(r_k);
    assign rd_en_o        = w_issue;
    assign mac_en_o       = r_pipe_vld[MemLatency-1];
    assign accumulate_o   = r_pipe_acc[MemLatency-1];
    assign result_valid_o = r_result_valid;
    assign tile_o         = r_tile;
    assign busy_o         = r_busy;
    assign done_o         = r_done;

endmodule

// File: tb/tb_dense_sequencer.sv
// Directed bench for dense_sequencer: per-cycle event logs compared against hand-derived timelines.
`timescale 1ns/1ps
module tb_dense_sequencer;

    localparam int unsigned AddrW = 16;
    localparam int unsigned LenW  = 12;
    localparam int ML   = 2;
    localparam int MacL = 1;

    typedef int iq_t[$];

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LenW-1:0]  in_len = '0;
    logic [LenW-1:0]  tiles = '0;
    logic             hold_i = 1'b0;
    logic             result_ready_i = 1'b1;

    logic [AddrW-1:0] wgt_addr, act_addr;
    logic             rd_en, mac_en, accumulate, result_valid, busy, done;
    logic [LenW-1:0]  tile;

    logic [3:0]       wgt_addr4, act_addr4;
    logic             rd_en4, mac_en4, acc4, valid4, busy4, done4;
    logic [LenW-1:0]  tile4;

    dense_sequencer #(.AddrW(AddrW), .LenW(LenW), .MemLatency(ML), .MacLatency(MacL)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_len_i(in_len), .tile_count_i(tiles),
        .hold_i(hold_i), .wgt_addr_o(wgt_addr), .act_addr_o(act_addr), .rd_en_o(rd_en),
        .mac_en_o(mac_en), .accumulate_o(accumulate), .result_valid_o(result_valid),
        .result_ready_i(result_ready_i), .tile_o(tile), .busy_o(busy), .done_o(done));

    dense_sequencer #(.AddrW(4), .LenW(LenW), .MemLatency(ML), .MacLatency(MacL)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_len_i(in_len), .tile_count_i(tiles),
        .hold_i(hold_i), .wgt_addr_o(wgt_addr4), .act_addr_o(act_addr4), .rd_en_o(rd_en4),
        .mac_en_o(mac_en4), .accumulate_o(acc4), .result_valid_o(valid4),
        .result_ready_i(result_ready_i), .tile_o(tile4), .busy_o(busy4), .done_o(done4));

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  t0 = 0;
    bit  hold_en = 1'b0;
    int  h1 = 0, h2 = 0;
    bit  rdy_en = 1'b0;
    int  rdy_lo = 0, rdy_hi = 0;
    int  acc_bad = 0;
    int  busy_cnt = 0;

    iq_t rd_cyc, rd_wgt, rd_act, rd_tile, rd_wgt4, rd_act4;
    iq_t mac_cyc, mac_acc, val_cyc, val_tile, hs_cyc, done_cyc;
    iq_t exp_q;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_q(input string tag, input iq_t got, input iq_t exp);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
        end
    endtask

    // Handshake-side stimulus driven per relative cycle
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        hold_i = hold_en && ((cyc - t0) == h1 || (cyc - t0) == h2);
        result_ready_i = !(rdy_en && (cyc - t0) >= rdy_lo && (cyc - t0) <= rdy_hi);
    end

    always @(negedge clk) begin : mon
        int rel;
        rel = cyc - t0;
        if (rd_en) begin
            rd_cyc.push_back(rel);
            rd_wgt.push_back(int'(wgt_addr));
            rd_act.push_back(int'(act_addr));
            rd_tile.push_back(int'(tile));
        end
        if (rd_en4) begin
            rd_wgt4.push_back(int'(wgt_addr4));
            rd_act4.push_back(int'(act_addr4));
        end
        if (mac_en) begin
            mac_cyc.push_back(rel);
            mac_acc.push_back(int'(accumulate));
        end
        if (accumulate && !mac_en) acc_bad++;
        if (result_valid) begin
            val_cyc.push_back(rel);
            val_tile.push_back(int'(tile));
        end
        if (result_valid && result_ready_i) hs_cyc.push_back(rel);
        if (done) done_cyc.push_back(rel);
        if (busy) busy_cnt++;
    end

    task automatic clear_logs();
        rd_cyc.delete(); rd_wgt.delete(); rd_act.delete(); rd_tile.delete();
        rd_wgt4.delete(); rd_act4.delete();
        mac_cyc.delete(); mac_acc.delete(); val_cyc.delete(); val_tile.delete();
        hs_cyc.delete(); done_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic start_pass(input int k, input int t);
        @(negedge clk);
        t0 = cyc + 1;
        @(posedge clk);
        #1;
        clear_logs();
        in_len = LenW'(k);
        tiles  = LenW'(t);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cyc.size() == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cyc.size() == 0) chk("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
    endtask

    // Hold-free timeline: each tile takes K reads, ML+MacL drain cycles and one handshake cycle
    task automatic check_pass(input string tag, input int k, input int t);
        iq_t ec, ew, ea, et, mc, ma, hs;
        int per;
        per = k + ML + MacL + 1;
        for (int ti = 0; ti < t; ti++) begin
            for (int j = 0; j < k; j++) begin
                ec.push_back(1 + ti * per + j);
                ew.push_back((ti * k + j) % 65536);
                ea.push_back(j);
                et.push_back(ti);
                mc.push_back(1 + ti * per + j + ML);
                ma.push_back((j != 0) ? 1 : 0);
            end
            hs.push_back(1 + ti * per + k + ML + MacL);
        end
        chk_q({tag, "_rd_cyc"}, rd_cyc, ec);
        chk_q({tag, "_wgt"}, rd_wgt, ew);
        chk_q({tag, "_act"}, rd_act, ea);
        chk_q({tag, "_tile"}, rd_tile, et);
        chk_q({tag, "_mac_cyc"}, mac_cyc, mc);
        chk_q({tag, "_acc"}, mac_acc, ma);
        chk_q({tag, "_hs"}, hs_cyc, hs);
        chk({tag, "_done_cnt"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk({tag, "_done_cyc"}, done_cyc[0], t * per + 1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_wgt", int'(wgt_addr), 0);
        chk("rst_act", int'(act_addr), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_mac_en", int'(mac_en), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_tile", int'(tile), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic pass K=4, T=1
        start_pass(4, 1);
        wait_done(100);
        exp_q = '{1, 2, 3, 4};       chk_q("basic_rd_cyc", rd_cyc, exp_q);
        exp_q = '{0, 1, 2, 3};       chk_q("basic_act", rd_act, exp_q);
        chk_q("basic_wgt", rd_wgt, exp_q);
        exp_q = '{3, 4, 5, 6};       chk_q("basic_mac_cyc", mac_cyc, exp_q);
        exp_q = '{0, 1, 1, 1};       chk_q("basic_acc", mac_acc, exp_q);
        exp_q = '{8};                chk_q("basic_valid", val_cyc, exp_q);
        exp_q = '{9};                chk_q("basic_done", done_cyc, exp_q);
        chk("basic_busy_cycles", busy_cnt, 8);

        // Multi-tile K=3, T=3
        start_pass(3, 3);
        wait_done(200);
        check_pass("multi", 3, 3);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8}; chk_q("multi_wgt_lit", rd_wgt, exp_q);
        chk("multi_hs_cnt", hs_cyc.size(), 3);

        // Hold on ISSUE cycles 2,3 and ready low for 5 cycles on tile 0
        hold_en = 1'b1; h1 = 2; h2 = 3;
        rdy_en  = 1'b1; rdy_lo = 10; rdy_hi = 14;
        start_pass(4, 2);
        wait_done(200);
        hold_en = 1'b0;
        rdy_en  = 1'b0;
        exp_q = '{1, 4, 5, 6, 16, 17, 18, 19};   chk_q("hold_rd_cyc", rd_cyc, exp_q);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};       chk_q("hold_wgt", rd_wgt, exp_q);
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};       chk_q("hold_act", rd_act, exp_q);
        exp_q = '{3, 6, 7, 8, 18, 19, 20, 21};   chk_q("hold_mac_cyc", mac_cyc, exp_q);
        exp_q = '{0, 1, 1, 1, 0, 1, 1, 1};       chk_q("hold_acc", mac_acc, exp_q);
        exp_q = '{10, 11, 12, 13, 14, 15, 23};   chk_q("hold_val_cyc", val_cyc, exp_q);
        exp_q = '{0, 0, 0, 0, 0, 0, 1};          chk_q("hold_val_tile", val_tile, exp_q);
        exp_q = '{15, 23};                       chk_q("hold_hs", hs_cyc, exp_q);
        exp_q = '{24};                           chk_q("hold_done", done_cyc, exp_q);

        // Zero length
        start_pass(0, 5);
        wait_done(20);
        exp_q = '{1};                chk_q("zero_k_done", done_cyc, exp_q);
        chk("zero_k_rd", rd_cyc.size(), 0);
        chk("zero_k_mac", mac_cyc.size(), 0);
        chk("zero_k_busy", busy_cnt, 0);
        start_pass(3, 0);
        wait_done(20);
        exp_q = '{1};                chk_q("zero_t_done", done_cyc, exp_q);
        chk("zero_t_rd", rd_cyc.size(), 0);
        chk("zero_t_mac", mac_cyc.size(), 0);

        // Start while busy is ignored
        start_pass(3, 1);
        @(posedge clk);
        #1;
        in_len = LenW'(7);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100);
        check_pass("busy_start", 3, 1);

        // Mid-run asynchronous reset in the third ISSUE cycle
        start_pass(8, 1);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_rd_en", int'(rd_en), 1);
        chk("pre_rst_act", int'(act_addr), 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wgt", int'(wgt_addr), 0);
        chk("mid_rst_act", int'(act_addr), 0);
        chk("mid_rst_rd_en", int'(rd_en), 0);
        chk("mid_rst_mac_en", int'(mac_en), 0);
        chk("mid_rst_acc", int'(accumulate), 0);
        chk("mid_rst_tile", int'(tile), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_pass(2, 1);
        wait_done(100);
        check_pass("post_rst", 2, 1);

        // Address wrap on the 4-bit instance
        start_pass(5, 4);
        wait_done(300);
        check_pass("wrap_wide", 5, 4);
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(i % 16);
        chk_q("wrap_wgt4", rd_wgt4, exp_q);
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(i % 5);
        chk_q("wrap_act4", rd_act4, exp_q);
        if (rd_wgt4.size() == 20) begin
            chk("wrap_t3_k0", rd_wgt4[15], 15);
            chk("wrap_t3_k1", rd_wgt4[16], 0);
            chk("wrap_t3_k4", rd_wgt4[19], 3);
        end else begin
            chk("wrap_t3_size", rd_wgt4.size(), 20);
        end

        chk("acc_without_mac", acc_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
